hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage integer core. Detects load-use hazards and taken-branch redirects, and sequences the shared multi-cycle multiply/divide unit (MDU). From these it drives the stall and flush controls for the PC, IF/ID and ID/EX registers. Sits beside the forwarding units in the ID/EX control path; store-data dependencies on a load are resolved by WB→MEM forwarding, so they never stall here.

## Interface
- REG_ADDR_W, 5, register address width
- MUL_CYCLES, 4, multiply occupancy in cycles (≥1)
- DIV_CYCLES, 32, divide occupancy in cycles (≥1)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ID_rs  in  REG_ADDR_W  rs of instruction in ID
- ID_rt  in  REG_ADDR_W  rt of instruction in ID
- ID_UseRs  in  1  ID instruction reads rs in EX
- ID_UseRt  in  1  ID instruction reads rt in EX
- ID_IsStore  in  1  ID instruction is a store (rt is store data)
- ID_MdStart  in  1  ID instruction is mult/div
- ID_MdIsDiv  in  1  qualifies ID_MdStart: 1 = divide
- ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo
- EX_MemRd  in  1  instruction in EX is a load
- EX_RegDstAddr  in  REG_ADDR_W  destination of instruction in EX
- EX_BranchTaken  in  1  branch/jump resolved taken in EX
- PC_Stall  out  1  hold PC
- IF_ID_Stall  out  1  hold IF/ID
- IF_ID_Flush  out  1  squash IF/ID
- ID_EX_Flush  out  1  insert bubble into ID/EX
- Md_Issue  out  1  one-cycle pulse: MDU start accepted
- MdBusy  out  1  MDU occupied
- MdDone  out  1  registered one-cycle pulse: HI/LO valid
- StallCnt  out  CNT_W  saturating count of PC_Stall cycles

## Operation
- load_use = EX_MemRd & (EX_RegDstAddr≠0) & ((ID_UseRs & ID_rs==EX_RegDstAddr) | (ID_UseRt & ID_rt==EX_RegDstAddr & ~ID_IsStore)).
- A store whose only match is rt does not stall. If rs also matches, it stalls.
- md_hazard = MdBusy & (ID_MdStart | ID_ReadsHiLo). This is a structural/data hazard on HI/LO.
- stall = (load_use | md_hazard) & ~EX_BranchTaken.
- On stall: PC_Stall = IF_ID_Stall = ID_EX_Flush = 1, IF_ID_Flush = 0.
- Branch priority: EX_BranchTaken → IF_ID_Flush = ID_EX_Flush = 1, PC_Stall = IF_ID_Stall = 0. The squashed ID instruction never stalls and never issues.
- Md_Issue = ID_MdStart & ~MdBusy & ~stall & ~EX_BranchTaken.
- MDU FSM, two states:
  - IDLE: on Md_Issue, load cnt = (ID_MdIsDiv ? DIV_CYCLES : MUL_CYCLES) − 1 and go to BUSY.
  - BUSY: if cnt==0, go to IDLE and set MdDone=1 for the next cycle; otherwise decrement cnt.
- MdBusy = (state==BUSY).
- MdDone is registered and high for exactly one cycle, the first IDLE cycle after BUSY. HI/LO may be read in that cycle with no stall.
- Issue in the MdDone cycle is legal. MdDone still pulses, and the new op enters BUSY next cycle.
- StallCnt increments on each cycle with PC_Stall=1 and saturates at all-ones.
- rst (asynchronous, any time, including mid-BUSY) → state=IDLE, cnt=0, MdDone=0, StallCnt=0.
  - Combinational outputs then follow inputs with MdBusy=0.
  - An in-flight MDU op is abandoned.

## Timing
- Reset values:
  - MdBusy=0, MdDone=0, StallCnt=0.
  - PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, Md_Issue are combinational from inputs; all are 0 when inputs are 0.
- load_use stall is zero-latency and lasts exactly one cycle: the load advances to MEM, and the hazard clears unless another load follows.
- MDU issued in cycle t:
  - MdBusy high cycles t+1 … t+N, with N=MUL_CYCLES or DIV_CYCLES.
  - MdDone high in cycle t+N+1.
  - A dependent mfhi/mflo held in ID stalls through t+N and proceeds in t+N+1.
- Branch flush is same-cycle combinational. The MDU FSM is unaffected by flushes once BUSY.

## Test plan
- Load to r5 in EX; ID add with rs=5, ID_UseRs=1 → PC_Stall=IF_ID_Stall=ID_EX_Flush=1 for one cycle, StallCnt 0→1. Same case with EX_RegDstAddr=0 → no stall.
- Load to r7 in EX; ID store with rt=7, rs=3 → no stall. Same store with rs=7 → one-cycle stall.
- mult issued at t (MUL_CYCLES=4), mflo in ID from t+1 → MdBusy high t+1..t+4, stall t+1..t+4, MdDone=1 at t+5 with no stall. div → 32 busy cycles, MdDone at t+33.
- load_use true with EX_BranchTaken=1 → IF_ID_Flush=ID_EX_Flush=1, PC_Stall=0, Md_Issue=0, StallCnt unchanged.
- Assert rst at the 10th BUSY cycle of a div → MdBusy=0 immediately, no MdDone pulse. A mult after reset release issues cleanly.
- Hold load_use for 2^CNT_W+5 cycles → StallCnt saturates at 0xFFFF and stays there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage core: load-use and HI/LO hazards,
// taken-branch squash, and sequencing of the shared multi-cycle MDU.
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] ID_rs,
   input  logic [REG_ADDR_W-1:0] ID_rt,
   input  logic                  ID_UseRs,
   input  logic                  ID_UseRt,
   input  logic                  ID_IsStore,
   input  logic                  ID_MdStart,
   input  logic                  ID_MdIsDiv,
   input  logic                  ID_ReadsHiLo,
   input  logic                  EX_MemRd,
   input  logic [REG_ADDR_W-1:0] EX_RegDstAddr,
   input  logic                  EX_BranchTaken,
   output logic                  PC_Stall,
   output logic                  IF_ID_Stall,
   output logic                  IF_ID_Flush,
   output logic                  ID_EX_Flush,
   output logic                  Md_Issue,
   output logic                  MdBusy,
   output logic                  MdDone,
   output logic [CNT_W-1:0]      StallCnt
);

   localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int MD_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [MD_W-1:0] MUL_LD = MD_W'(MUL_CYCLES - 1);
   localparam logic [MD_W-1:0] DIV_LD = MD_W'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t            r_state, w_state_nxt;
   logic [MD_W-1:0]   r_cnt, w_cnt_nxt;
   logic              r_done, w_done_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_load_use, w_md_hazard, w_stall;

   // Store data (rt) is forwarded WB->MEM, so an rt-only match on a store is not a hazard.
   assign w_load_use = EX_MemRd && (EX_RegDstAddr != '0) &&
                       ((ID_UseRs && (ID_rs == EX_RegDstAddr)) ||
                        (ID_UseRt && (ID_rt == EX_RegDstAddr) && !ID_IsStore));
   assign w_md_hazard = MdBusy && (ID_MdStart || ID_ReadsHiLo);
   assign w_stall     = (w_load_use || w_md_hazard) && !EX_BranchTaken;

   assign MdBusy      = (r_state == S_BUSY);
   assign MdDone      = r_done;
   assign StallCnt    = r_stall_cnt;
   assign PC_Stall    = w_stall;
   assign IF_ID_Stall = w_stall;
   assign IF_ID_Flush = EX_BranchTaken;
   assign ID_EX_Flush = w_stall || EX_BranchTaken;
   assign Md_Issue    = ID_MdStart && !MdBusy && !w_stall && !EX_BranchTaken;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Md_Issue) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = ID_MdIsDiv ? DIV_LD : MUL_LD;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of single-cycle vectors plus hand-written MDU,
// async-reset and counter-saturation sequences, checked through a scoreboard queue.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_rs, ID_rt, EX_RegDstAddr;
   logic       ID_UseRs, ID_UseRt, ID_IsStore, ID_MdStart, ID_MdIsDiv, ID_ReadsHiLo;
   logic       EX_MemRd, EX_BranchTaken;
   logic       PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, Md_Issue, MdBusy, MdDone;
   logic [15:0] StallCnt;

   hazard_ctrl #(.REG_ADDR_W(5), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
      .ID_IsStore(ID_IsStore), .ID_MdStart(ID_MdStart), .ID_MdIsDiv(ID_MdIsDiv),
      .ID_ReadsHiLo(ID_ReadsHiLo), .EX_MemRd(EX_MemRd), .EX_RegDstAddr(EX_RegDstAddr),
      .EX_BranchTaken(EX_BranchTaken),
      .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush), .Md_Issue(Md_Issue), .MdBusy(MdBusy), .MdDone(MdDone),
      .StallCnt(StallCnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs, rt;
      logic       urs, urt, st, mds, div, hilo, memrd;
      logic [4:0] dst;
      logic       br;
   } in_t;

   // ctl = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush}
   typedef struct packed {
      logic [3:0]  ctl;
      logic        issue, busy, done;
      logic [15:0] cnt;
   } out_t;

   typedef struct { in_t i; out_t o; } vec_t;

   localparam logic [3:0] NO = 4'b0000, ST = 4'b1101, BR = 4'b0011;

   out_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   exp_cnt;
   vec_t tbl[13];

   function automatic in_t mk_in(input logic [4:0] rs, rt, input logic urs, urt, st, mds, div,
                                 hilo, memrd, input logic [4:0] dst, input logic br);
      in_t v;
      v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.st = st; v.mds = mds; v.div = div;
      v.hilo = hilo; v.memrd = memrd; v.dst = dst; v.br = br;
      return v;
   endfunction

   function automatic out_t mk_out(input logic [3:0] ctl, input logic issue, busy, done,
                                   input int cnt);
      out_t o;
      o.ctl = ctl; o.issue = issue; o.busy = busy; o.done = done; o.cnt = 16'(cnt);
      return o;
   endfunction

   task automatic drive(input in_t v);
      ID_rs = v.rs; ID_rt = v.rt; ID_UseRs = v.urs; ID_UseRt = v.urt; ID_IsStore = v.st;
      ID_MdStart = v.mds; ID_MdIsDiv = v.div; ID_ReadsHiLo = v.hilo; EX_MemRd = v.memrd;
      EX_RegDstAddr = v.dst; EX_BranchTaken = v.br;
   endtask

   task automatic check(input string nm);
      out_t e, a;
      e = sb.pop_front();
      a.ctl = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush};
      a.issue = Md_Issue; a.busy = MdBusy; a.done = MdDone; a.cnt = StallCnt;
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got ctl=%b iss=%b busy=%b done=%b cnt=%0d, want ctl=%b iss=%b busy=%b done=%b cnt=%0d",
                  nm, a.ctl, a.issue, a.busy, a.done, a.cnt, e.ctl, e.issue, e.busy, e.done, e.cnt);
      end
   endtask

   task automatic step(input in_t v, input out_t e, input string nm);
      @(posedge clk); #1;
      drive(v);
      sb.push_back(e);
      @(negedge clk);
      check(nm);
   endtask

   // Step with the bench's own running stall count; advances it when a stall is expected.
   task automatic stepc(input in_t v, input logic [3:0] ctl, input logic issue, busy, done,
                        input string nm);
      step(v, mk_out(ctl, issue, busy, done, exp_cnt), nm);
      if (ctl[3] && exp_cnt < 65535) exp_cnt++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      drive('0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_cnt = 0;
   endtask

   in_t z, mul, div, mflo, mulh, lu;

   initial begin
      rst = 1'b1;
      drive('0);
      z    = '0;
      mul  = mk_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      div  = mk_in(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      mflo = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      lu   = mk_in(5, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0);

      //                 rs rt urs urt st mds div hilo memrd dst br
      tbl[0]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(NO, 0, 0, 0, 0)};
      tbl[1]  = '{mk_in(5, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0), mk_out(ST, 0, 0, 0, 0)};
      tbl[2]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(NO, 0, 0, 0, 1)};
      tbl[3]  = '{mk_in(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(NO, 0, 0, 0, 1)};
      tbl[4]  = '{mk_in(3, 7, 1, 1, 1, 0, 0, 0, 1, 7, 0), mk_out(NO, 0, 0, 0, 1)};
      tbl[5]  = '{mk_in(7, 7, 1, 1, 1, 0, 0, 0, 1, 7, 0), mk_out(ST, 0, 0, 0, 1)};
      tbl[6]  = '{mk_in(3, 7, 1, 1, 0, 0, 0, 0, 1, 7, 0), mk_out(ST, 0, 0, 0, 2)};
      tbl[7]  = '{mk_in(3, 7, 1, 0, 0, 0, 0, 0, 1, 7, 0), mk_out(NO, 0, 0, 0, 3)};
      tbl[8]  = '{mk_in(7, 0, 1, 0, 0, 0, 0, 0, 0, 7, 0), mk_out(NO, 0, 0, 0, 3)};
      tbl[9]  = '{mk_in(5, 0, 1, 0, 0, 1, 0, 0, 1, 5, 1), mk_out(BR, 0, 0, 0, 3)};
      tbl[10] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mk_out(BR, 0, 0, 0, 3)};
      tbl[11] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(NO, 0, 0, 0, 3)};
      tbl[12] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_out(NO, 0, 0, 0, 3)};

      // Reset state while rst is held.
      #2;
      sb.push_back(mk_out(NO, 0, 0, 0, 0));
      check("reset_state");
      @(posedge clk); #1 rst = 1'b0;

      foreach (tbl[k]) step(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

      // mult at t, mflo waiting in ID: busy/stall t+1..t+4, done t+5 without stall.
      do_reset();
      stepc(mul, NO, 1, 0, 0, "mul_issue");
      for (int i = 1; i <= 4; i++) stepc(mflo, ST, 0, 1, 0, $sformatf("mul_busy%0d", i));
      stepc(mflo, NO, 0, 0, 1, "mul_done");
      stepc(z, NO, 0, 0, 0, "mul_after");

      // div with a mult waiting behind it; the mult issues in the MdDone cycle.
      do_reset();
      stepc(div, NO, 1, 0, 0, "div_issue");
      for (int i = 1; i <= 32; i++) stepc(mul, ST, 0, 1, 0, $sformatf("div_busy%0d", i));
      stepc(mul, NO, 1, 0, 1, "div_done_reissue");
      for (int i = 1; i <= 4; i++) stepc(z, NO, 0, 1, 0, $sformatf("mul2_busy%0d", i));
      stepc(z, NO, 0, 0, 1, "mul2_done");
      stepc(z, NO, 0, 0, 0, "mul2_after");

      // Branch while busy: flush only, FSM keeps counting.
      do_reset();
      stepc(mul, NO, 1, 0, 0, "br_mul_issue");
      mulh = mk_in(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
      stepc(mulh, BR, 0, 1, 0, "br_while_busy");
      for (int i = 2; i <= 4; i++) stepc(z, NO, 0, 1, 0, $sformatf("br_busy%0d", i));
      stepc(z, NO, 0, 0, 1, "br_mul_done");

      // Async reset in the 10th busy cycle of a div: abandoned, no MdDone ever.
      do_reset();
      stepc(div, NO, 1, 0, 0, "rdiv_issue");
      for (int i = 1; i <= 10; i++) stepc(z, NO, 0, 1, 0, $sformatf("rdiv_busy%0d", i));
      rst = 1'b1;
      #1;
      sb.push_back(mk_out(NO, 0, 0, 0, 0));
      check("rst_async");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 30; i++) stepc(z, NO, 0, 0, 0, $sformatf("rdiv_quiet%0d", i));
      stepc(mul, NO, 1, 0, 0, "rmul_issue");
      for (int i = 1; i <= 4; i++) stepc(z, NO, 0, 1, 0, $sformatf("rmul_busy%0d", i));
      stepc(z, NO, 0, 0, 1, "rmul_done");

      // Held load-use: StallCnt climbs to 0xFFFF and sticks.
      do_reset();
      for (int i = 0; i < 65541; i++) begin
         if (i >= 65532) begin
            step(lu, mk_out(ST, 0, 0, 0, (i > 65535) ? 65535 : i), $sformatf("sat%0d", i));
         end else begin
            @(posedge clk); #1;
            drive(lu);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
